// File: rtl/multu_seq.sv
// Sequential unsigned multiplier (MULTU) with HI/LO result registers.
// Radix-2 shift-add: WIDTH calculation cycles, then one DONE cycle.
module multu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mf_req,
  input  logic             rd_sel,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   mplier_shift;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    sum          = '0;
    mplier_shift = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = src_a;
          mplier_d = src_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Carry out of the add becomes the new accumulator MSB; the bit
        // shifted out of the accumulator fills the multiplier from the top.
        sum          = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        mplier_shift = {sum[0], mplier_q};
        acc_d        = sum[WIDTH:1];
        mplier_d     = mplier_shift[WIDTH:1];
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_d    = acc_d;
          lo_d    = mplier_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the reset clears the full datapath, not just the FSM, so an
  // abandoned multiply leaves nothing behind in HI/LO or the operand regs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign stall   = mf_req & busy;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_multu_seq.sv
// Directed self-checking bench for multu_seq: latency, product values,
// ignored restarts, MF stall behaviour and asynchronous reset.
module tb_multu_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mf_req;
  logic             rd_sel;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  int busy_cycles;
  int done_cnt;
  int done_at;
  bit hold_ok;
  bit stall_ok;
  bit finished;
  bit quiet_ok;

  multu_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .src_a   (src_a),
    .src_b   (src_b),
    .mf_req  (mf_req),
    .rd_sel  (rd_sel),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one multiply and follows it to the first IDLE cycle. Sample i is
  // taken 1 time unit after edge E0+i. Optionally re-pulses start with other
  // operands at sample restart_at and raises mf_req from sample mf_from.
  task automatic run_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] prev_hi, input logic [WIDTH-1:0] prev_lo,
                          input int restart_at, input logic [WIDTH-1:0] ra,
                          input logic [WIDTH-1:0] rb, input int mf_from);
    int i;
    busy_cycles = 0;
    done_cnt    = 0;
    done_at     = -1;
    hold_ok     = 1'b1;
    stall_ok    = 1'b1;
    finished    = 1'b0;
    start = 1'b1;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    src_a = ~a;
    src_b = ~b;
    i = 0;
    while (!finished && i <= 60) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        done_at = i;
        if (!busy) hold_ok = 1'b0;
      end
      if (busy && !done &&
          (hi !== prev_hi || lo !== prev_lo || rd_data !== (rd_sel ? prev_hi : prev_lo)))
        hold_ok = 1'b0;
      if (stall !== (mf_req && i <= WIDTH)) stall_ok = 1'b0;
      if (!busy) begin
        finished = 1'b1;
      end else begin
        start = (i == restart_at);
        if (i == restart_at) begin
          src_a = ra;
          src_b = rb;
        end
        mf_req = (mf_from >= 0) && (i + 1 >= mf_from);
        tick();
        i++;
      end
    end
    start = 1'b0;
    check("finished_in_budget", 64'(finished), 64'd1);
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    src_a  = '0;
    src_b  = '0;
    mf_req = 1'b0;
    rd_sel = 1'b0;

    // Asynchronous reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hi",    64'(hi),    64'd0);
    check("rst_lo",    64'(lo),    64'd0);

    // Start held through reset release; first clean edge accepts it.
    start = 1'b1;
    src_a = 32'd3;
    src_b = 32'd5;
    tick();
    check("start_in_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // 3 x 5
    run_mult(32'd3, 32'd5, 32'h0, 32'h0, -1, 32'h0, 32'h0, -1);
    check("m1_hi",          64'(hi),          64'h0);
    check("m1_lo",          64'(lo),          64'hF);
    check("m1_done_cnt",    64'(done_cnt),    64'd1);
    check("m1_done_at",     64'(done_at),     64'd32);
    check("m1_busy_cycles", 64'(busy_cycles), 64'd33);
    check("m1_hold",        64'(hold_ok),     64'd1);
    check("m1_rd_data",     64'(rd_data),     64'hF);

    // All-ones operands exercise the carry out of every add.
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hF, -1, 32'h0, 32'h0, -1);
    check("m2_hi",          64'(hi),          64'hFFFF_FFFE);
    check("m2_lo",          64'(lo),          64'h0000_0001);
    check("m2_busy_cycles", 64'(busy_cycles), 64'd33);
    check("m2_hold",        64'(hold_ok),     64'd1);

    // MSB times two lands in HI; read both halves through rd_data.
    run_mult(32'h8000_0000, 32'd2, 32'hFFFF_FFFE, 32'h1, -1, 32'h0, 32'h0, -1);
    check("m3_hi", 64'(hi), 64'h1);
    check("m3_lo", 64'(lo), 64'h0);
    rd_sel = 1'b1;
    #1;
    check("m3_rd_hi", 64'(rd_data), 64'h1);
    rd_sel = 1'b0;
    #1;
    check("m3_rd_lo", 64'(rd_data), 64'h0);

    // Second start at cycle 10 of a running multiply is ignored.
    run_mult(32'd3, 32'd5, 32'h1, 32'h0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("m4_hi",          64'(hi),          64'h0);
    check("m4_lo",          64'(lo),          64'hF);
    check("m4_done_cnt",    64'(done_cnt),    64'd1);
    check("m4_busy_cycles", 64'(busy_cycles), 64'd33);
    check("m4_hold",        64'(hold_ok),     64'd1);
    quiet_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) quiet_ok = 1'b0;
    end
    check("m4_no_queue", 64'(quiet_ok), 64'd1);

    // A start arriving during DONE is ignored as well.
    run_mult(32'h0001_0000, 32'h0001_0000, 32'h0, 32'hF, 32, 32'd5, 32'd5, -1);
    check("m5_hi",          64'(hi),          64'h1);
    check("m5_lo",          64'(lo),          64'h0);
    check("m5_done_cnt",    64'(done_cnt),    64'd1);
    check("m5_busy_cycles", 64'(busy_cycles), 64'd33);
    quiet_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (busy !== 1'b0) quiet_ok = 1'b0;
    end
    check("m5_no_capture", 64'(quiet_ok), 64'd1);

    // MFLO arriving at cycle 5 stalls until the product lands.
    run_mult(32'd7, 32'd9, 32'h1, 32'h0, -1, 32'h0, 32'h0, 5);
    check("m6_stall_window", 64'(stall_ok), 64'd1);
    check("m6_idle_stall",   64'(stall),    64'd0);
    check("m6_rd_data",      64'(rd_data),  64'h3F);
    check("m6_hold",         64'(hold_ok),  64'd1);
    mf_req = 1'b0;

    // Reset between edges at CALC cycle 16 abandons the multiply.
    start = 1'b1;
    src_a = 32'h1234_5678;
    src_b = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check("m7_busy_pre_rst", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("m7_rst_busy",    64'(busy),    64'd0);
    check("m7_rst_done",    64'(done),    64'd0);
    check("m7_rst_stall",   64'(stall),   64'd0);
    check("m7_rst_hi",      64'(hi),      64'h0);
    check("m7_rst_lo",      64'(lo),      64'h0);
    check("m7_rst_rd_data", 64'(rd_data), 64'h0);
    tick();
    rst = 1'b0;
    quiet_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || hi !== '0 || lo !== '0) quiet_ok = 1'b0;
    end
    check("m7_no_done_after_rst", 64'(quiet_ok), 64'd1);

    run_mult(32'd7, 32'd6, 32'h0, 32'h0, -1, 32'h0, 32'h0, -1);
    check("m8_hi",          64'(hi),          64'h0);
    check("m8_lo",          64'(lo),          64'h2A);
    check("m8_done_cnt",    64'(done_cnt),    64'd1);
    check("m8_busy_cycles", 64'(busy_cycles), 64'd33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
